// File: rtl/cpu_pkg.sv
// Shared pipeline-control types: hazard FSM encoding, control bundle and load-use decode.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STALL  = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_FREEZE = 2'd3
    } hz_state_t;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic id_ex_write;
        logic mem_hold;
        logic if_flush;
        logic id_flush;
    } hz_ctrl_t;

    localparam hz_ctrl_t CTRL_RUN    = 6'b111_000;
    localparam hz_ctrl_t CTRL_STALL  = 6'b001_001;
    localparam hz_ctrl_t CTRL_FLUSH  = 6'b111_011;
    localparam hz_ctrl_t CTRL_FREEZE = 6'b000_100;

    // x0 is hard-wired zero, so a load targeting it can never create a dependency.
    function automatic logic load_use(
        input logic       ex_mem_read,
        input logic [4:0] ex_rd,
        input logic       use_rs1,
        input logic [4:0] rs1,
        input logic       use_rs2,
        input logic [4:0] rs2
    );
        return ex_mem_read && (ex_rd != 5'd0) &&
               ((use_rs1 && (rs1 == ex_rd)) || (use_rs2 && (rs2 == ex_rd)));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear that wins over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_q;

    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = sat_inc(cnt_q);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory freeze, branch flush and load-use stall,
// with a registered state tracker and saturating stall/flush statistics.
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_taken,
    input  logic             dmem_busy,
    input  logic             clr_stats,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_write,
    output logic             mem_hold,
    output logic             if_flush,
    output logic             id_flush,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    hz_state_t state_d;
    hz_state_t state_q;
    hz_ctrl_t  ctrl;
    logic      lu;
    logic      stall_inc;
    logic      flush_inc;

    assign lu = load_use(ex_mem_read, ex_rd, id_use_rs1, id_rs1, id_use_rs2, id_rs2);

    // Controls are decoded straight from the inputs; the state register only
    // records which hazard was serviced, so reset never disturbs the decode.
    always_comb begin
        ctrl    = CTRL_RUN;
        state_d = ST_RUN;
        if (dmem_busy) begin
            ctrl    = CTRL_FREEZE;
            state_d = ST_FREEZE;
        end else if (ex_taken) begin
            ctrl    = CTRL_FLUSH;
            state_d = ST_FLUSH;
        end else if (lu) begin
            ctrl    = CTRL_STALL;
            state_d = ST_STALL;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // A multi-cycle flush (back-to-back taken) counts as one event.
    assign stall_inc = (state_d == ST_STALL) || (state_d == ST_FREEZE);
    assign flush_inc = (state_d == ST_FLUSH) && (state_q != ST_FLUSH);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk  (clk),
        .rstn (rstn),
        .inc  (stall_inc),
        .clr  (clr_stats),
        .cnt  (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk  (clk),
        .rstn (rstn),
        .inc  (flush_inc),
        .clr  (clr_stats),
        .cnt  (flush_cnt)
    );

    assign pc_write    = ctrl.pc_write;
    assign if_id_write = ctrl.if_id_write;
    assign id_ex_write = ctrl.id_ex_write;
    assign mem_hold    = ctrl.mem_hold;
    assign if_flush    = ctrl.if_flush;
    assign id_flush    = ctrl.id_flush;
    assign state       = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: decode vector table plus counter/reset sequences.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_use_rs1, id_use_rs2, ex_mem_read, ex_taken, dmem_busy, clr_stats;
    logic        pc_write, if_id_write, id_ex_write, mem_hold, if_flush, id_flush;
    logic [1:0]  state;
    logic [15:0] stall_cnt, flush_cnt;
    logic        pc_write4, if_id_write4, id_ex_write4, mem_hold4, if_flush4, id_flush4;
    logic [1:0]  state4;
    logic [3:0]  stall_cnt4, flush_cnt4;

    int total = 0;
    int passed = 0;

    localparam logic [1:0] S_RUN = 2'd0, S_STALL = 2'd1, S_FLUSH = 2'd2, S_FREEZE = 2'd3;

    always #5 clk = ~clk;

    hazard_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .rstn(rstn), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_taken(ex_taken),
        .dmem_busy(dmem_busy), .clr_stats(clr_stats),
        .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
        .mem_hold(mem_hold), .if_flush(if_flush), .id_flush(id_flush),
        .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rstn(rstn), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_taken(ex_taken),
        .dmem_busy(dmem_busy), .clr_stats(clr_stats),
        .pc_write(pc_write4), .if_id_write(if_id_write4), .id_ex_write(id_ex_write4),
        .mem_hold(mem_hold4), .if_flush(if_flush4), .id_flush(id_flush4),
        .state(state4), .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
    );

    typedef struct {
        string      name;
        logic       mr;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       tk;
        logic       busy;
        logic [5:0] exp_ctrl;   // {pc,if_id,id_ex,hold,if_flush,id_flush}
        logic [1:0] exp_state;
    } vec_t;

    vec_t vecs[12];

    function automatic logic [5:0] ctrl_now();
        return {pc_write, if_id_write, id_ex_write, mem_hold, if_flush, id_flush};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic idle();
        ex_mem_read = 0; ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
        id_use_rs1 = 0; id_use_rs2 = 0; ex_taken = 0; dmem_busy = 0; clr_stats = 0;
    endtask

    task automatic set_lu();
        ex_mem_read = 1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        idle();
        clr_stats = 1;
        tick();
        clr_stats = 0;
    endtask

    initial begin
        vecs[0]  = '{"none",        0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 6'b111000, S_RUN};
        vecs[1]  = '{"lu_rs1",      1, 5'd5, 5'd5, 5'd3, 1, 0, 0, 0, 6'b001001, S_STALL};
        vecs[2]  = '{"lu_rs2",      1, 5'd9, 5'd1, 5'd9, 0, 1, 0, 0, 6'b001001, S_STALL};
        vecs[3]  = '{"rs2_unused",  1, 5'd9, 5'd1, 5'd9, 1, 0, 0, 0, 6'b111000, S_RUN};
        vecs[4]  = '{"not_load",    0, 5'd5, 5'd5, 5'd5, 1, 1, 0, 0, 6'b111000, S_RUN};
        vecs[5]  = '{"rd_x0",       1, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0, 6'b111000, S_RUN};
        vecs[6]  = '{"taken",       0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 6'b111011, S_FLUSH};
        vecs[7]  = '{"taken_lu",    1, 5'd7, 5'd7, 5'd0, 1, 0, 1, 0, 6'b111011, S_FLUSH};
        vecs[8]  = '{"busy",        0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 6'b000100, S_FREEZE};
        vecs[9]  = '{"busy_all",    1, 5'd7, 5'd7, 5'd7, 1, 1, 1, 1, 6'b000100, S_FREEZE};
        vecs[10] = '{"rs_differ",   1, 5'd4, 5'd3, 5'd2, 1, 1, 0, 0, 6'b111000, S_RUN};
        vecs[11] = '{"lu_both",     1, 5'd31, 5'd31, 5'd31, 1, 1, 0, 0, 6'b001001, S_STALL};

        idle();
        rstn = 0;
        repeat (2) tick();
        chk("rst_state", 32'(state), 32'(S_RUN));
        chk("rst_stall_cnt", 32'(stall_cnt), 0);
        chk("rst_flush_cnt", 32'(flush_cnt), 0);
        chk("rst_ctrl", 32'(ctrl_now()), 32'(6'b111000));
        rstn = 1;
        tick();

        // Decode table: controls before the edge, state after it.
        for (int i = 0; i < 12; i++) begin
            ex_mem_read = vecs[i].mr; ex_rd = vecs[i].rd;
            id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2;
            id_use_rs1 = vecs[i].u1; id_use_rs2 = vecs[i].u2;
            ex_taken = vecs[i].tk; dmem_busy = vecs[i].busy;
            #1;
            chk({vecs[i].name, "_ctrl"}, 32'(ctrl_now()), 32'(vecs[i].exp_ctrl));
            tick();
            chk({vecs[i].name, "_state"}, 32'(state), 32'(vecs[i].exp_state));
        end

        // Single load-use stall.
        clear_stats();
        chk("clr_stall", 32'(stall_cnt), 0);
        chk("clr_flush", 32'(flush_cnt), 0);
        set_lu();
        tick();
        idle();
        chk("lu_stall_cnt", 32'(stall_cnt), 1);

        // One-cycle taken branch.
        clear_stats();
        ex_taken = 1;
        tick();
        idle();
        chk("tk1_state", 32'(state), 32'(S_FLUSH));
        chk("tk1_flush_cnt", 32'(flush_cnt), 1);

        // Two consecutive taken cycles count once.
        clear_stats();
        ex_taken = 1;
        tick();
        tick();
        chk("tk2_state", 32'(state), 32'(S_FLUSH));
        idle();
        tick();
        chk("tk2_flush_cnt", 32'(flush_cnt), 1);
        chk("tk2_back_run", 32'(state), 32'(S_RUN));

        // Busy for three cycles with a pending load-use, then the stall.
        clear_stats();
        set_lu();
        dmem_busy = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("frz_hold", 32'(mem_hold), 1);
            tick();
            chk("frz_state", 32'(state), 32'(S_FREEZE));
        end
        dmem_busy = 0;
        #1;
        chk("frz_then_lu_ctrl", 32'(ctrl_now()), 32'(6'b001001));
        tick();
        chk("frz_then_stall", 32'(state), 32'(S_STALL));
        chk("frz_stall_cnt", 32'(stall_cnt), 4);
        idle();

        // Clear wins over a same-cycle stall.
        tick();
        set_lu();
        clr_stats = 1;
        tick();
        idle();
        chk("clr_vs_stall", 32'(stall_cnt), 0);
        chk("clr_vs_stall_st", 32'(state), 32'(S_STALL));

        // Saturation: 20 stalls on the 4-bit and 16-bit instances.
        clear_stats();
        set_lu();
        repeat (20) tick();
        idle();
        chk("sat4_stall_cnt", 32'(stall_cnt4), 15);
        chk("sat16_stall_cnt", 32'(stall_cnt), 20);
        tick();
        chk("sat4_hold", 32'(stall_cnt4), 15);

        // Asynchronous reset in the middle of a freeze.
        clear_stats();
        ex_taken = 1;
        tick();
        ex_taken = 0;
        dmem_busy = 1;
        tick();
        tick();
        chk("pre_rst_state", 32'(state), 32'(S_FREEZE));
        chk("pre_rst_stall", 32'(stall_cnt), 2);
        #2;
        rstn = 0;
        #1;
        chk("async_rst_state", 32'(state), 32'(S_RUN));
        chk("async_rst_stall", 32'(stall_cnt), 0);
        chk("async_rst_flush", 32'(flush_cnt), 0);
        tick();
        chk("rst_held_state", 32'(state), 32'(S_RUN));
        chk("rst_held_stall", 32'(stall_cnt), 0);
        idle();
        rstn = 1;
        tick();
        chk("post_rst_state", 32'(state), 32'(S_RUN));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
